// File: rtl/diag_run_seq_pkg.sv
// Package wrapper so the EBOX encodings can be imported by the sequencer and its bench.
package diag_run_seq_pkg;
`include "ebox.svh"
endpackage

// File: rtl/diag_run_seq_if.sv
// Signal bundle for the diag run sequencer command and CON status handshake.
interface diag_run_seq_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       run;
    logic       ebox_halted;
    logic       diag_ctl_func;
    logic [2:0] ds;
    logic       busy;
    logic       done;
    logic       timeout;

    // A command transfers on a rising clk edge where cmd_valid and cmd_ready are both 1;
    // cmd_valid seen while cmd_ready is 0 is dropped, never held over.
    modport master (
        output cmd_valid, cmd, run, ebox_halted,
        input  cmd_ready, diag_ctl_func, ds, busy, done, timeout
    );

    modport slave (
        input  cmd_valid, cmd, run, ebox_halted,
        output cmd_ready, diag_ctl_func, ds, busy, done, timeout
    );
endinterface

// File: rtl/ebox.svh
// Shared EBOX diagnostic encodings: command codes, diag control codes, FSM states.
`ifndef EBOX_SVH
`define EBOX_SVH

typedef enum logic [1:0] {
    CMD_HALT     = 2'd0,
    CMD_START    = 2'd1,
    CMD_CONTINUE = 2'd2,
    CMD_STEP     = 2'd3
} cmd_e;

localparam logic [2:0] DIAG_CLR_RUN     = 3'd0;
localparam logic [2:0] DIAG_SET_RUN     = 3'd1;
localparam logic [2:0] DIAG_CONTINUE    = 3'd2;
localparam logic [2:0] DIAG_IR_STROBE   = 3'd4;
localparam logic [2:0] DIAG_DRAM_STROBE = 3'd5;

localparam logic [2:0] ST_IDLE   = 3'd0;
localparam logic [2:0] ST_STROBE = 3'd1;
localparam logic [2:0] ST_GAP    = 3'd2;
localparam logic [2:0] ST_WAIT   = 3'd3;
localparam logic [2:0] ST_FINISH = 3'd4;
localparam logic [2:0] ST_FAIL   = 3'd5;

`endif

// File: rtl/diag_run_seq.sv
// Issues the diag control strobe list for HALT/START/CONTINUE/STEP, then waits for
// CON run/halt status to settle, reporting DONE or TIMEOUT.
module diag_run_seq
    import diag_run_seq_pkg::*;
#(
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       CMD_VALID,
    input  logic [1:0] CMD,
    output logic       CMD_READY,
    input  logic       RUN,
    input  logic       EBOX_HALTED,
    output logic       DIAG_CTL_FUNC_01x,
    output logic [2:0] DS,
    output logic       BUSY,
    output logic       DONE,
    output logic       TIMEOUT
);

    localparam logic [2:0] SCNT_LAST = 3'(STROBE_CYCLES - 1);
    localparam logic [9:0] WCNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    cmd_e       cmd_q, cmd_d;
    logic       second_q, second_d;
    logic [2:0] scnt_q, scnt_d;
    logic [9:0] wcnt_q, wcnt_d;
    logic       seen_low_q, seen_low_d;
    logic       complete;

    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       func_q, func_d;
    logic [2:0] ds_q, ds_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;

    function automatic logic has_second(input cmd_e c);
        return (c == CMD_START) || (c == CMD_STEP);
    endfunction

    function automatic logic [2:0] strobe_code(input cmd_e c, input logic second);
        case (c)
            CMD_HALT:     return DIAG_CLR_RUN;
            CMD_START:    return second ? DIAG_CONTINUE : DIAG_SET_RUN;
            CMD_CONTINUE: return DIAG_CONTINUE;
            default:      return second ? DIAG_CONTINUE : DIAG_CLR_RUN;
        endcase
    endfunction

    always_comb begin
        case (cmd_q)
            CMD_HALT:     complete = !RUN;
            CMD_START:    complete = RUN;
            CMD_CONTINUE: complete = RUN;
            default:      complete = seen_low_q && EBOX_HALTED;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        second_d   = second_q;
        scnt_d     = scnt_q;
        wcnt_d     = wcnt_q;
        seen_low_d = seen_low_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    state_d  = ST_STROBE;
                    cmd_d    = cmd_e'(CMD);
                    second_d = 1'b0;
                    scnt_d   = 3'd0;
                end
            end
            ST_STROBE: begin
                if (scnt_q == SCNT_LAST) begin
                    if (has_second(cmd_q) && !second_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d    = ST_WAIT;
                        wcnt_d     = 10'd0;
                        seen_low_d = 1'b0;
                    end
                end else begin
                    scnt_d = scnt_q + 3'd1;
                end
            end
            ST_GAP: begin
                state_d  = ST_STROBE;
                second_d = 1'b1;
                scnt_d   = 3'd0;
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q + 10'd1;
                if (!EBOX_HALTED) seen_low_d = 1'b1;
                // Completion is tested first so it wins over the timeout limit.
                if (complete)                 state_d = ST_FINISH;
                else if (wcnt_q == WCNT_LAST) state_d = ST_FAIL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with the FSM.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        func_d    = (state_d == ST_STROBE);
        ds_d      = func_d ? strobe_code(cmd_d, second_d) : 3'd0;
        done_d    = (state_d == ST_FINISH);
        timeout_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_HALT;
            second_q   <= 1'b0;
            scnt_q     <= 3'd0;
            wcnt_q     <= 10'd0;
            seen_low_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            func_q     <= 1'b0;
            ds_q       <= 3'd0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            second_q   <= second_d;
            scnt_q     <= scnt_d;
            wcnt_q     <= wcnt_d;
            seen_low_q <= seen_low_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            func_q     <= func_d;
            ds_q       <= ds_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign CMD_READY         = ready_q;
    assign BUSY              = busy_q;
    assign DIAG_CTL_FUNC_01x = func_q;
    assign DS                = ds_q;
    assign DONE              = done_q;
    assign TIMEOUT           = timeout_q;

endmodule
